// File: rtl/sat_pkg.sv
// Shared definitions for the shared saturation arbiter: width helpers and
// output FSM state encoding.
package sat_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int out_w(input int in_w, input int sat_w);
    return in_w - sat_w;
  endfunction

  // Channel id is at least one bit wide even for degenerate channel counts.
  function automatic int ch_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/sat_clip.sv
// Signed saturating narrow: drops the top SAT_WIDTH bits, clipping to the
// largest/smallest representable value when they carry information.
module sat_clip
  import sat_pkg::*;
#(
  parameter  int IN_WIDTH  = 32,
  parameter  int SAT_WIDTH = 16,
  localparam int OUT_W     = out_w(IN_WIDTH, SAT_WIDTH)
) (
  input  logic [IN_WIDTH-1:0] din,
  output logic [OUT_W-1:0]    dout,
  output logic                ovf
);

  logic w_sign;

  assign w_sign = din[IN_WIDTH-1];

  // Removed bits plus the new sign bit must all replicate the original sign.
  assign ovf  = (din[IN_WIDTH-2 -: SAT_WIDTH] != {SAT_WIDTH{w_sign}});
  assign dout = ovf ? {w_sign, {(OUT_W-1){~w_sign}}} : din[OUT_W-1:0];

endmodule

// File: rtl/sat_share_arb.sv
// Round-robin arbiter feeding one registered saturation stage, with a
// valid/ready output and sticky per-channel saturation counters.
module sat_share_arb
  import sat_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int IN_WIDTH  = 32,
  parameter  int SAT_WIDTH = 16,
  parameter  int CNT_WIDTH = 16,
  localparam int OUT_W     = out_w(IN_WIDTH, SAT_WIDTH),
  localparam int CH_W      = ch_w(NUM_CH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           req_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0]  req_data,
  output logic [NUM_CH-1:0]           req_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic [CH_W-1:0]             out_ch,
  output logic                        out_sat,
  input  logic                        cnt_clr,
  output logic [NUM_CH*CNT_WIDTH-1:0] sat_cnt
);

  state_t                              r_state, w_state_nxt;
  logic   [CH_W-1:0]                   r_ptr, w_ptr_nxt, w_gnt_ch;
  logic   [NUM_CH-1:0]                 w_grant;
  logic                                w_gnt_any;
  logic                                w_accept;
  logic   [IN_WIDTH-1:0]               w_din;
  logic   [OUT_W-1:0]                  w_clip;
  logic                                w_ovf;
  logic   [OUT_W-1:0]                  r_data;
  logic   [CH_W-1:0]                   r_ch;
  logic                                r_sat;
  logic   [NUM_CH-1:0][CNT_WIDTH-1:0]  r_cnt;

  assign w_accept = (r_state == ST_EMPTY) | out_ready;

  // Two ascending passes: channels at/after ptr first, then the wrap-around.
  always_comb begin
    w_grant   = '0;
    w_gnt_ch  = '0;
    w_gnt_any = 1'b0;
    w_ptr_nxt = r_ptr;
    if (w_accept && !rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_gnt_any && req_valid[k] && (k >= int'(r_ptr))) begin
          w_gnt_any  = 1'b1;
          w_grant[k] = 1'b1;
          w_gnt_ch   = CH_W'(k);
          w_ptr_nxt  = (k == NUM_CH - 1) ? '0 : CH_W'(k + 1);
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_gnt_any && req_valid[k] && (k < int'(r_ptr))) begin
          w_gnt_any  = 1'b1;
          w_grant[k] = 1'b1;
          w_gnt_ch   = CH_W'(k);
          w_ptr_nxt  = (k == NUM_CH - 1) ? '0 : CH_W'(k + 1);
        end
      end
    end
  end

  assign req_ready = w_grant;

  always_comb begin
    w_din = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant[k]) w_din = req_data[k*IN_WIDTH +: IN_WIDTH];
    end
  end

  sat_clip #(
    .IN_WIDTH  (IN_WIDTH),
    .SAT_WIDTH (SAT_WIDTH)
  ) u_clip (
    .din  (w_din),
    .dout (w_clip),
    .ovf  (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_gnt_any)               w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_gnt_any) w_state_nxt = ST_EMPTY;
      default:                               w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_data <= '0;
      r_ch   <= '0;
      r_sat  <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_gnt_any) begin
        r_data <= w_clip;
        r_ch   <= w_gnt_ch;
        r_sat  <= w_ovf;
      end
    end
  end

  assign out_data = r_data;
  assign out_ch   = r_ch;
  assign out_sat  = r_sat;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst || cnt_clr)
        r_cnt[g] <= '0;
      else if (w_grant[g] && w_ovf && (r_cnt[g] != {CNT_WIDTH{1'b1}}))
        r_cnt[g] <= r_cnt[g] + 1'b1;
    end
    assign sat_cnt[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

endmodule

// File: tb/tb_sat_share_arb.sv
// Directed bench for sat_share_arb: vector table for arbitration/saturation
// plus hand sequences for counter saturation, clear priority and reset.
module tb_sat_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_sat;
  logic        cnt_clr;
  logic [63:0] sat_cnt;

  logic [3:0]  b_req_ready;
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_sat;
  logic [7:0]  b_sat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sat_share_arb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
    .cnt_clr(cnt_clr), .sat_cnt(sat_cnt)
  );

  sat_share_arb #(.CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b_req_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ch(b_out_ch), .out_sat(b_out_sat),
    .cnt_clr(cnt_clr), .sat_cnt(b_sat_cnt)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d0, d1, d2, d3;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [15:0] e_data;
    logic [1:0]  e_ch;
    logic        e_sat;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d0, d1, d2, d3,
                              input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                              input logic [15:0] e_data, input logic [1:0] e_ch,
                              input logic e_sat);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.d3 = d3; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_data = e_data; r.e_ch = e_ch; r.e_sat = e_sat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d0, d1, d2, d3, input logic ordy);
    req_valid = v;
    req_data  = {d3, d2, d1, d0};
    out_ready = ordy;
  endtask

  function automatic logic [15:0] cnt16(input int k);
    logic [63:0] t;
    t = sat_cnt;
    return t[k*16 +: 16];
  endfunction

  function automatic logic [1:0] cnt2(input int k);
    logic [7:0] t;
    t = b_sat_cnt;
    return t[k*2 +: 2];
  endfunction

  localparam logic [31:0] D10 = 32'h10, D11 = 32'h11, D12 = 32'h12, D13 = 32'h13;

  initial begin
    vecs[0]  = mk(4'h1, 32'h00001234, 0, 0, 0, 1, 4'b0001, 1, 16'h1234, 0, 0);
    vecs[1]  = mk(4'h0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'h0, 0, 0);
    vecs[2]  = mk(4'h2, 0, 32'h00012345, 0, 0, 1, 4'b0010, 1, 16'h7FFF, 1, 1);
    vecs[3]  = mk(4'h2, 0, 32'hFFFF8000, 0, 0, 1, 4'b0010, 1, 16'h8000, 1, 0);
    vecs[4]  = mk(4'h2, 0, 32'hFFFE0000, 0, 0, 1, 4'b0010, 1, 16'h8000, 1, 1);
    vecs[5]  = mk(4'h8, 0, 0, 0, 32'h5, 1, 4'b1000, 1, 16'h0005, 3, 0);
    vecs[6]  = mk(4'hF, D10, D11, D12, D13, 1, 4'b0001, 1, 16'h0010, 0, 0);
    vecs[7]  = mk(4'hF, D10, D11, D12, D13, 1, 4'b0010, 1, 16'h0011, 1, 0);
    vecs[8]  = mk(4'hF, D10, D11, D12, D13, 1, 4'b0100, 1, 16'h0012, 2, 0);
    vecs[9]  = mk(4'hF, D10, D11, D12, D13, 1, 4'b1000, 1, 16'h0013, 3, 0);
    vecs[10] = mk(4'hF, D10, D11, D12, D13, 1, 4'b0001, 1, 16'h0010, 0, 0);
    vecs[11] = mk(4'hF, D10, D11, D12, D13, 0, 4'b0000, 1, 16'h0010, 0, 0);
    vecs[12] = mk(4'hF, D10, D11, D12, D13, 0, 4'b0000, 1, 16'h0010, 0, 0);
    vecs[13] = mk(4'hF, D10, D11, D12, D13, 0, 4'b0000, 1, 16'h0010, 0, 0);
    vecs[14] = mk(4'hF, D10, D11, D12, D13, 1, 4'b0010, 1, 16'h0011, 1, 0);
    vecs[15] = mk(4'h0, 0, 0, 0, 0, 0, 4'b0000, 1, 16'h0011, 1, 0);
    vecs[16] = mk(4'h0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'h0, 0, 0);
    vecs[17] = mk(4'h4, 0, 0, 32'hFFFFFFFE, 0, 1, 4'b0100, 1, 16'hFFFE, 2, 0);
    vecs[18] = mk(4'h4, 0, 0, 32'h80000000, 0, 1, 4'b0100, 1, 16'h8000, 2, 1);
    vecs[19] = mk(4'h4, 0, 0, 32'h00007FFF, 0, 1, 4'b0100, 1, 16'h7FFF, 2, 0);
    vecs[20] = mk(4'h4, 0, 0, 32'h00008000, 0, 1, 4'b0100, 1, 16'h7FFF, 2, 1);
    vecs[21] = mk(4'h0, 0, 0, 0, 0, 1, 4'b0000, 0, 16'h0, 0, 0);

    // Reset with requests pending: no grants, everything cleared.
    rst = 1'b1;
    cnt_clr = 1'b0;
    drive(4'hF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
    step();
    step();
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_sat_cnt", sat_cnt, 64'h0);
    rst = 1'b0;
    drive(4'h0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].v, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
      step();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].e_data));
        chk($sformatf("v%0d_out_ch", i), 64'(out_ch), 64'(vecs[i].e_ch));
        chk($sformatf("v%0d_out_sat", i), 64'(out_sat), 64'(vecs[i].e_sat));
      end
    end
    chk("cnt0_after_table", 64'(cnt16(0)), 64'd0);
    chk("cnt1_after_table", 64'(cnt16(1)), 64'd2);
    chk("cnt2_after_table", 64'(cnt16(2)), 64'd2);
    chk("cnt3_after_table", 64'(cnt16(3)), 64'd0);

    // Clear, then push the 2-bit counter past its maximum.
    cnt_clr = 1'b1;
    step();
    chk("clr_cnt16", sat_cnt, 64'h0);
    chk("clr_cnt2", 64'(b_sat_cnt), 64'h0);
    cnt_clr = 1'b0;
    drive(4'h4, 0, 0, 32'h7FFFFFFF, 0, 1);
    repeat (5) step();
    chk("stick_cnt2", 64'(cnt2(2)), 64'd3);
    chk("stick_cnt16", 64'(cnt16(2)), 64'd5);
    chk("stick_out_data", 64'(out_data), 64'h7FFF);
    chk("stick_out_sat", 64'(out_sat), 64'h1);
    cnt_clr = 1'b1;
    step();
    chk("clr_wins_cnt2", 64'(cnt2(2)), 64'd0);
    chk("clr_wins_cnt16", 64'(cnt16(2)), 64'd0);
    chk("clr_wins_out_sat", 64'(out_sat), 64'h1);
    cnt_clr = 1'b0;
    step();
    chk("resume_cnt16", 64'(cnt16(2)), 64'd1);
    drive(4'h0, 0, 0, 0, 0, 1);
    step();
    chk("drain_out_valid", 64'(out_valid), 64'h0);

    // Mid-stream reset while FULL with ptr parked at 3.
    drive(4'h4, 0, 0, 32'h7FFFFFFF, 0, 1);
    step();
    chk("prerst_out_valid", 64'(out_valid), 64'h1);
    chk("prerst_cnt2", 64'(cnt16(2)), 64'd2);
    rst = 1'b1;
    drive(4'hF, D10, D11, D12, D13, 0);
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    step();
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_out_ch", 64'(out_ch), 64'h0);
    chk("midrst_out_sat", 64'(out_sat), 64'h0);
    chk("midrst_sat_cnt", sat_cnt, 64'h0);
    rst = 1'b0;
    drive(4'hF, D10, D11, D12, D13, 1);
    #1;
    chk("postrst_req_ready", 64'(req_ready), 64'b0001);
    step();
    chk("postrst_out_valid", 64'(out_valid), 64'h1);
    chk("postrst_out_ch", 64'(out_ch), 64'h0);
    chk("postrst_out_data", 64'(out_data), 64'h0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
